// File: rtl/cache_pkg.sv
// Shared data-cache definitions: tag word layout, line geometry and flush-engine states.
package cache_pkg;

    localparam int unsigned TAG_VALID_BIT = 23;
    localparam int unsigned TAG_DIRTY_BIT = 22;
    localparam int unsigned TAG_ADDR_MSB  = 21;
    localparam int unsigned LINE_W        = 256;
    localparam int unsigned LINE_OFF_W    = 5;

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StCheck,
        StWrite,
        StClear,
        StDone
    } flush_state_e;

endpackage

// File: rtl/mem_line_req.sv
// Registered single-line memory write request: captured on load, held until ack.
module mem_line_req #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned LINE_W = 256
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [LINE_W-1:0] data_i,
    input  logic              ack_i,
    output logic              enable_o,
    output logic              write_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [LINE_W-1:0] data_o,
    output logic              done_o
);

    logic              enable_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] data_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            enable_q <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
        end else if (load_i) begin
            enable_q <= 1'b1;
            addr_q   <= addr_i;
            data_q   <= data_i;
        end else if (enable_q && ack_i) begin
            // Acks arriving with no request outstanding are ignored.
            enable_q <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
        end
    end

    assign enable_o = enable_q;
    assign write_o  = enable_q;
    assign addr_o   = addr_q;
    assign data_o   = data_q;
    assign done_o   = enable_q & ack_i;

endmodule

// File: rtl/dcache_flush_engine.sv
// Walks every cache line, writes valid+dirty lines back to memory and clears their dirty bit.
module dcache_flush_engine #(
    parameter int unsigned NUM_LINES = 32,
    parameter int unsigned INDEX_W   = 5,
    parameter int unsigned TAG_W     = 24,
    parameter int unsigned LINE_W    = 256,
    parameter int unsigned ADDR_W    = 32
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               flush_start_i,
    output logic               flush_busy_o,
    output logic               flush_done_o,
    output logic [INDEX_W:0]   lines_written_o,
    output logic [INDEX_W-1:0] sram_idx_o,
    input  logic [TAG_W-1:0]   sram_tag_i,
    input  logic [LINE_W-1:0]  sram_data_i,
    output logic               sram_tag_we_o,
    output logic [TAG_W-1:0]   sram_tag_o,
    output logic               mem_enable_o,
    output logic               mem_write_o,
    output logic [ADDR_W-1:0]  mem_addr_o,
    output logic [LINE_W-1:0]  mem_data_o,
    input  logic               mem_ack_i
);
    import cache_pkg::*;

    flush_state_e       state_q, state_d;
    logic [INDEX_W-1:0] idx_q, idx_d;
    logic [INDEX_W:0]   cnt_q, cnt_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic               req_load;
    logic               req_done;
    logic               idx_last;
    logic               line_dirty;
    logic [ADDR_W-1:0]  line_addr;

    assign idx_last   = (idx_q == INDEX_W'(NUM_LINES - 1));
    assign line_dirty = sram_tag_i[TAG_VALID_BIT] & sram_tag_i[TAG_DIRTY_BIT];
    assign line_addr  = ADDR_W'({sram_tag_i[TAG_ADDR_MSB:0], idx_q, LINE_OFF_W'(0)});

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= StIdle;
            idx_q   <= '0;
            cnt_q   <= '0;
            tag_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            tag_q   <= tag_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        cnt_d         = cnt_q;
        tag_d         = tag_q;
        req_load      = 1'b0;
        sram_tag_we_o = 1'b0;
        flush_done_o  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (flush_start_i) begin
                    idx_d   = '0;
                    cnt_d   = '0;
                    state_d = StRead;
                end
            end
            StRead: state_d = StCheck;
            StCheck: begin
                tag_d = sram_tag_i;
                if (line_dirty) begin
                    req_load = 1'b1;
                    state_d  = StWrite;
                end else if (idx_last) begin
                    state_d = StDone;
                end else begin
                    idx_d   = idx_q + INDEX_W'(1);
                    state_d = StRead;
                end
            end
            StWrite: begin
                if (req_done) state_d = StClear;
            end
            StClear: begin
                sram_tag_we_o = 1'b1;
                cnt_d         = cnt_q + (INDEX_W + 1)'(1);
                if (idx_last) begin
                    state_d = StDone;
                end else begin
                    idx_d   = idx_q + INDEX_W'(1);
                    state_d = StRead;
                end
            end
            StDone: begin
                flush_done_o = 1'b1;
                state_d      = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Write-back data is the latched tag with only the dirty bit dropped.
    always_comb begin
        sram_tag_o                = tag_q;
        sram_tag_o[TAG_DIRTY_BIT] = 1'b0;
    end

    assign flush_busy_o    = (state_q != StIdle) && (state_q != StDone);
    assign lines_written_o = cnt_q;
    assign sram_idx_o      = idx_q;

    mem_line_req #(
        .ADDR_W (ADDR_W),
        .LINE_W (LINE_W)
    ) u_req (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .load_i   (req_load),
        .addr_i   (line_addr),
        .data_i   (sram_data_i),
        .ack_i    (mem_ack_i),
        .enable_o (mem_enable_o),
        .write_o  (mem_write_o),
        .addr_o   (mem_addr_o),
        .data_o   (mem_data_o),
        .done_o   (req_done)
    );

endmodule

// File: tb/tb_dcache_flush_engine.sv
// Bench for dcache_flush_engine: SRAM and memory models plus a line-list reference model.
module tb_dcache_flush_engine;

    localparam int NL = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         flush_start = 1'b0;
    logic         flush_busy, flush_done;
    logic [5:0]   lines_written;
    logic [4:0]   sram_idx;
    logic [23:0]  tag_rd;
    logic [255:0] data_rd;
    logic         tag_we;
    logic [23:0]  tag_wr;
    logic         mem_en, mem_wr;
    logic [31:0]  mem_addr;
    logic [255:0] mem_data;
    logic         mem_ack;
    logic         resp_ack = 1'b0;
    logic         spur_ack = 1'b0;

    always #5 clk = ~clk;
    assign mem_ack = resp_ack | spur_ack;

    dcache_flush_engine dut (
        .clk_i           (clk),
        .rst_i           (rst_n),
        .flush_start_i   (flush_start),
        .flush_busy_o    (flush_busy),
        .flush_done_o    (flush_done),
        .lines_written_o (lines_written),
        .sram_idx_o      (sram_idx),
        .sram_tag_i      (tag_rd),
        .sram_data_i     (data_rd),
        .sram_tag_we_o   (tag_we),
        .sram_tag_o      (tag_wr),
        .mem_enable_o    (mem_en),
        .mem_write_o     (mem_wr),
        .mem_addr_o      (mem_addr),
        .mem_data_o      (mem_data),
        .mem_ack_i       (mem_ack)
    );

    int total = 0;
    int bad = 0;

    // Cache SRAM model: one-cycle read latency, tag writes from the engine.
    logic [23:0]  tags [NL];
    logic [23:0]  init_tags [NL];
    logic [255:0] datas [NL];
    logic         load_en = 1'b0;
    int           tag_wr_cnt = 0;

    always @(posedge clk) begin
        tag_rd  <= tags[sram_idx];
        data_rd <= datas[sram_idx];
        if (load_en) begin
            tags <= init_tags;
        end else if (tag_we) begin
            tags[sram_idx] <= tag_wr;
            tag_wr_cnt     <= tag_wr_cnt + 1;
        end
    end

    // Memory responder: acks after ack_delay cycles of enable, logs each accepted request.
    int           ack_delay = 1;
    int           hold = 0;
    int           last_hold = 0;
    int           unstable = 0;
    logic [31:0]  cap_a;
    logic [255:0] cap_d;
    logic [31:0]  req_addr_q [$];
    logic [255:0] req_data_q [$];

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_ack <= 1'b0;
            hold     <= 0;
        end else if (resp_ack) begin
            resp_ack <= 1'b0;
            hold     <= 0;
        end else if (mem_en) begin
            if (hold == 0) begin
                cap_a <= mem_addr;
                cap_d <= mem_data;
            end
            if ((mem_wr !== 1'b1) || (hold != 0 && (mem_addr !== cap_a || mem_data !== cap_d)))
                unstable <= unstable + 1;
            if (hold + 1 == ack_delay) begin
                resp_ack  <= 1'b1;
                last_hold <= hold + 1;
                req_addr_q.push_back(mem_addr);
                req_data_q.push_back(mem_data);
            end
            hold <= hold + 1;
        end
    end

    // Reference model: expected request list, final tags, count and completion time.
    logic [31:0]  exp_addr [$];
    logic [255:0] exp_data [$];
    logic [23:0]  exp_tags [NL];
    int           exp_cnt;
    int           exp_cyc;

    task automatic model();
        logic [23:0] t;
        logic [4:0]  ii;
        exp_addr.delete();
        exp_data.delete();
        exp_cnt = 0;
        exp_cyc = 1;
        for (int i = 0; i < NL; i++) begin
            t  = init_tags[i];
            ii = i[4:0];
            if (t[23] && t[22]) begin
                exp_addr.push_back({t[21:0], ii, 5'b0});
                exp_data.push_back(datas[i]);
                exp_tags[i] = t & ~24'h400000;
                exp_cnt++;
                exp_cyc += 3 + ack_delay;
            end else begin
                exp_tags[i] = t;
                exp_cyc += 2;
            end
        end
    endtask

    task automatic chk(input string name, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic set_mem();
        @(negedge clk);
        load_en = 1'b1;
        @(posedge clk);
        #1 load_en = 1'b0;
    endtask

    task automatic clear_lines();
        for (int i = 0; i < NL; i++) begin
            init_tags[i] = 24'h0;
            datas[i]     = 256'h0;
        end
    endtask

    // Runs one flush; cyc is the index of the clock edge (start edge = 0) that samples done.
    task automatic run_flush(input string name, input bit inject, output int cyc);
        @(negedge clk);
        flush_start = 1'b1;
        @(posedge clk);
        #1 flush_start = 1'b0;
        cyc = 0;
        while (cyc < 4000) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) chk({name, ".busy"}, flush_busy, 1'b1);
            flush_start = inject && (cyc == 1);
            spur_ack    = inject && (cyc == 1);
            if (flush_done) break;
        end
        flush_start = 1'b0;
        spur_ack    = 1'b0;
        chk({name, ".done_seen"}, flush_done, 1'b1);
    endtask

    task automatic check_run(input string name, input bit inject);
        int base;
        int uns0;
        int tw0;
        int cyc;
        base = req_addr_q.size();
        uns0 = unstable;
        tw0  = tag_wr_cnt;
        model();
        set_mem();
        run_flush(name, inject, cyc);
        chk({name, ".cycles"}, cyc, exp_cyc);
        chk({name, ".busy_at_done"}, flush_busy, 1'b0);
        repeat (3) @(negedge clk);
        chk({name, ".done_pulse"}, flush_done, 1'b0);
        chk({name, ".idle"}, flush_busy, 1'b0);
        chk({name, ".count"}, lines_written, exp_cnt);
        chk({name, ".nreq"}, req_addr_q.size() - base, exp_addr.size());
        for (int k = 0; k < exp_addr.size() && base + k < req_addr_q.size(); k++) begin
            chk($sformatf("%s.addr%0d", name, k), req_addr_q[base + k], exp_addr[k]);
            chk($sformatf("%s.data%0d", name, k), req_data_q[base + k], exp_data[k]);
        end
        for (int i = 0; i < NL; i++)
            chk($sformatf("%s.tag%0d", name, i), tags[i], exp_tags[i]);
        chk({name, ".tag_writes"}, tag_wr_cnt - tw0, exp_cnt);
        chk({name, ".stable"}, unstable - uns0, 0);
        if (exp_cnt > 0) chk({name, ".hold"}, last_hold, ack_delay);
    endtask

    initial begin
        int          n;
        int          nreq0;
        logic [31:0] rv;
        clear_lines();
        #12;
        chk("rst.busy", flush_busy, 1'b0);
        chk("rst.done", flush_done, 1'b0);
        chk("rst.count", lines_written, 6'd0);
        chk("rst.idx", sram_idx, 5'd0);
        chk("rst.mem_en", mem_en, 1'b0);
        chk("rst.mem_addr", mem_addr, 32'h0);
        chk("rst.tag_we", tag_we, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        check_run("clean", 1'b0);

        ack_delay       = 10;
        init_tags[3]    = 24'hC00001;
        datas[3]        = 256'hA5;
        check_run("one", 1'b0);
        chk("one.addr_fixed", req_addr_q[req_addr_q.size() - 1], 32'h460);
        chk("one.tag3_fixed", tags[3], 24'h800001);

        clear_lines();
        init_tags[7] = 24'h400002;
        check_run("inv_dirty", 1'b0);

        ack_delay = 2;
        for (int i = 0; i < NL; i++) begin
            init_tags[i] = 24'hC00000;
            datas[i]     = {8{$urandom}};
        end
        check_run("all", 1'b0);

        for (int r = 0; r < 4; r++) begin
            ack_delay = $urandom_range(1, 6);
            for (int i = 0; i < NL; i++) begin
                rv           = $urandom;
                init_tags[i] = rv[23:0];
                datas[i]     = {8{$urandom}};
            end
            check_run($sformatf("rnd%0d", r), r < 2);
        end

        // Asynchronous reset in the middle of a write-back.
        clear_lines();
        ack_delay    = 10;
        init_tags[3] = 24'hC00001;
        datas[3]     = 256'hA5;
        set_mem();
        nreq0 = req_addr_q.size();
        @(negedge clk);
        flush_start = 1'b1;
        @(negedge clk);
        flush_start = 1'b0;
        n = 0;
        while (!mem_en && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("arst.reached_write", mem_en, 1'b1);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst.busy", flush_busy, 1'b0);
        chk("arst.mem_en", mem_en, 1'b0);
        chk("arst.mem_wr", mem_wr, 1'b0);
        chk("arst.mem_addr", mem_addr, 32'h0);
        chk("arst.mem_data", mem_data, 256'h0);
        chk("arst.idx", sram_idx, 5'd0);
        chk("arst.tag_o", tag_wr, 24'h0);
        chk("arst.count", lines_written, 6'd0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("arst.no_req", req_addr_q.size() - nreq0, 0);
        chk("arst.tag3_kept", tags[3], 24'hC00001);
        check_run("redo", 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dcache_flush_engine.md
Name: dcache_flush_engine

Overview:
- Hardware write-back engine that walks every data-cache line and writes each valid, dirty line to data memory, then clears its dirty bit.
- Acts as the initiator on the same 256-bit line interface that the data memory responds on (enable/write/addr/data out, ack/data in).
- Sits beside dcache; a top-level mux hands it the memory port and the cache SRAM ports while flush_busy_o is high.
- Replaces the simulation-only backdoor flush at end of test.

Parameters:
- NUM_LINES, 32, cache lines to walk (power of two).
- INDEX_W, 5, log2(NUM_LINES).
- TAG_W, 24, tag SRAM word: bit 23 valid, bit 22 dirty, bits 21:0 address tag.
- LINE_W, 256, cache line / memory word width.
- ADDR_W, 32, byte address width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-low reset.
- flush_start_i  in  1  one-cycle request; accepted only in IDLE.
- flush_busy_o  out  1  high from the cycle after acceptance until DONE.
- flush_done_o  out  1  one-cycle pulse on completion.
- lines_written_o  out  INDEX_W+1  count of lines written back in the last or current flush.
- sram_idx_o  out  INDEX_W  tag/data SRAM index.
- sram_tag_i  in  TAG_W  tag word; valid one cycle after sram_idx_o.
- sram_data_i  in  LINE_W  data line; same timing as sram_tag_i.
- sram_tag_we_o  out  1  tag write strobe.
- sram_tag_o  out  TAG_W  tag write data.
- mem_enable_o  out  1  memory request.
- mem_write_o  out  1  always 1 when mem_enable_o is high.
- mem_addr_o  out  ADDR_W  byte address of the line.
- mem_data_o  out  LINE_W  line data.
- mem_ack_i  in  1  one-cycle completion pulse from memory.

Behaviour:
- Reset (async, rst_i low): state IDLE. All outputs 0, including index, counter and mem_* outputs. Reset mid-transaction abandons the request; memory is reset by the same rst_i.
- States:
  - IDLE: on flush_start_i, set idx=0 and lines_written=0, go to READ.
  - READ: drive sram_idx_o=idx, go to CHECK.
  - CHECK: latch sram_tag_i and sram_data_i. If valid&dirty, go to WRITE. Otherwise, if idx==NUM_LINES-1 go to DONE, else idx++ and go to READ.
  - WRITE: mem_enable_o=1 and mem_write_o=1. mem_addr_o={tag[21:0], idx, 5'b0}. mem_data_o is the latched line. All held stable until mem_ack_i is sampled high, then go to CLEAR. There is no timeout.
  - CLEAR: mem_enable_o=0. sram_tag_we_o=1 for one cycle with sram_tag_o = latched tag with bit 22 cleared. lines_written++. Then go to DONE if last, else idx++ and go to READ.
  - DONE: flush_done_o=1 for one cycle, go to IDLE.
- Timing:
  - Clean line costs 2 cycles.
  - Dirty line costs 2 + (cycles until ack) + 1 cycles.
  - All-clean flush: flush_done_o is high exactly 2*NUM_LINES+1 cycles after the edge that samples flush_start_i.
- flush_busy_o = (state != IDLE && state != DONE).
- flush_start_i outside IDLE is ignored; it is not queued.
- mem_ack_i outside WRITE is ignored.
- Invalid lines with the dirty bit set are skipped; they are never written.
- lines_written_o holds its value after DONE and is cleared on the next accepted start. Width INDEX_W+1 so that NUM_LINES itself is representable.
- Index wraps never: the walk ends at NUM_LINES-1.

Decomposition:
- Shared package cache_pkg holds:
  - Tag field constants: TAG_VALID_BIT=23, TAG_DIRTY_BIT=22, TAG_ADDR_MSB=21.
  - LINE_W and the line-offset width (5).
  - The flush-state enum.
- Shared with dcache and the flush-address formation.
- One sub-module: mem_line_req, the WRITE-state request holder that registers addr/data/enable and releases them on ack. It is reusable by the dcache write-back path.

Test Plan:
- All 32 tags 0, pulse start -> no mem_enable_o; flush_done_o 65 cycles after the start edge; lines_written_o=0.
- Index 3 tag 24'hC00001, data 256'hA5, ack 10 cycles after enable -> exactly one request: addr 32'h460, data 256'hA5, write=1, held stable 10 cycles. Tag index 3 rewritten as 24'h800001. Count=1.
- Index 7 tag 24'h400002 (dirty, not valid) -> no memory request; tag is not rewritten.
- All 32 lines tag 24'hC00000 -> 32 requests in ascending address order 0x000, 0x020, ... 0x3E0; lines_written_o=32; every dirty bit cleared.
- Start pulsed again while busy, and a spurious mem_ack_i in READ -> both ignored; request count unchanged.
- rst_i low during WRITE at index 3 -> all outputs 0 immediately (asynchronously); IDLE; a later start redoes the full flush correctly.
